// File: rtl/jump_controller.sv
// Producer side of the jump interface: debounces the player buttons, issues
// single-cycle jump requests to the block field and tracks column, score and game over.
module jump_controller #(
   parameter int DEBOUNCE_MS = 5,
   parameter int JUMP_MS     = 40,
   parameter int NUM_COLS    = 7,
   parameter int START_COL   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        module_en,
   input  logic        one_ms_tick,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        jump_fail,
   output logic        jump_left,
   output logic        jump_right,
   output logic        busy,
   output logic        game_over,
   output logic [2:0]  char_col,
   output logic [15:0] score
);

   localparam logic [2:0] DEB_LIMIT  = DEBOUNCE_MS[2:0];
   localparam logic [5:0] JUMP_LIMIT = JUMP_MS[5:0];
   localparam logic [2:0] COL_MAX    = 3'(NUM_COLS - 1);
   localparam logic [2:0] COL_START  = START_COL[2:0];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      JUMP  = 2'd2,
      FAIL  = 2'd3
   } state_t;

   // Index 0 is the left button, index 1 the right button.
   logic [1:0]      meta_r;
   logic [1:0]      sync_r;
   logic [1:0]      deb_r;
   logic [1:0]      deb_d_r;
   logic [1:0][2:0] cnt_r;
   logic [1:0]      press_s;
   logic            left_only_s;
   logic            right_only_s;

   state_t          state_r;
   state_t          state_next_s;
   logic [5:0]      ms_cnt_r;
   logic [5:0]      ms_next_s;
   logic            jl_s;
   logic            jr_s;
   logic [2:0]      col_next_s;
   logic [15:0]     score_next_s;

   // Two-flop synchronisers and per-button debounce counters advanced on the ms tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r  <= 2'b00;
         sync_r  <= 2'b00;
         deb_r   <= 2'b00;
         deb_d_r <= 2'b00;
         cnt_r   <= '0;
      end else begin
         meta_r  <= {btn_right, btn_left};
         sync_r  <= meta_r;
         deb_d_r <= deb_r;
         for (int i = 0; i < 2; i++) begin
            if (one_ms_tick) begin
               if (sync_r[i] != deb_r[i]) begin
                  if (cnt_r[i] == DEB_LIMIT - 3'd1) begin
                     deb_r[i] <= sync_r[i];
                     cnt_r[i] <= 3'd0;
                  end else begin
                     cnt_r[i] <= cnt_r[i] + 3'd1;
                  end
               end else begin
                  cnt_r[i] <= 3'd0;
               end
            end
         end
      end
   end

   assign press_s      = deb_r & ~deb_d_r;
   assign left_only_s  = (press_s == 2'b01);
   assign right_only_s = (press_s == 2'b10);

   // State register together with the registered outputs and jump bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         ms_cnt_r   <= 6'd0;
         jump_left  <= 1'b0;
         jump_right <= 1'b0;
         busy       <= 1'b0;
         game_over  <= 1'b0;
         char_col   <= COL_START;
         score      <= 16'd0;
      end else begin
         state_r    <= state_next_s;
         ms_cnt_r   <= ms_next_s;
         jump_left  <= jl_s;
         jump_right <= jr_s;
         busy       <= (state_next_s == JUMP);
         game_over  <= (state_next_s == FAIL);
         char_col   <= col_next_s;
         score      <= score_next_s;
      end
   end

   // Next-state logic; a failed landing wins over enable loss and any press.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (module_en) state_next_s = READY;
            else           state_next_s = IDLE;
         end
         READY: begin
            if (jump_fail)                                  state_next_s = FAIL;
            else if (!module_en)                            state_next_s = IDLE;
            else if (left_only_s && char_col != 3'd0)       state_next_s = JUMP;
            else if (right_only_s && char_col != COL_MAX)   state_next_s = JUMP;
            else                                            state_next_s = READY;
         end
         JUMP: begin
            if (jump_fail)                                             state_next_s = FAIL;
            else if (!module_en)                                       state_next_s = IDLE;
            else if (one_ms_tick && ms_cnt_r == JUMP_LIMIT - 6'd1)     state_next_s = READY;
            else                                                       state_next_s = JUMP;
         end
         FAIL:    state_next_s = FAIL;
         default: state_next_s = IDLE;
      endcase
   end

   // Next values for the pulses, column, score and the busy-window ms counter.
   always_comb begin
      jl_s         = 1'b0;
      jr_s         = 1'b0;
      col_next_s   = char_col;
      score_next_s = score;
      ms_next_s    = 6'd0;
      if (state_r == READY && module_en && !jump_fail) begin
         if (left_only_s && char_col != 3'd0) begin
            jl_s         = 1'b1;
            col_next_s   = char_col - 3'd1;
            score_next_s = (score == 16'hFFFF) ? score : score + 16'd1;
         end else if (right_only_s && char_col != COL_MAX) begin
            jr_s         = 1'b1;
            col_next_s   = char_col + 3'd1;
            score_next_s = (score == 16'hFFFF) ? score : score + 16'd1;
         end else begin
            jl_s = 1'b0;
         end
      end else if (state_r == JUMP && module_en && !jump_fail) begin
         if (one_ms_tick) begin
            if (ms_cnt_r == JUMP_LIMIT - 6'd1) ms_next_s = 6'd0;
            else                               ms_next_s = ms_cnt_r + 6'd1;
         end else begin
            ms_next_s = ms_cnt_r;
         end
      end else begin
         ms_next_s = 6'd0;
      end
   end

endmodule

// File: tb/tb_jump_controller.sv
// Scoreboard bench for jump_controller: expected jump pulses are queued when a
// press is driven and checked by a monitor whenever the DUT issues a pulse.
module tb_jump_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        module_en;
   logic        one_ms_tick;
   logic        btn_left;
   logic        btn_right;
   logic        jump_fail;
   logic        jump_left;
   logic        jump_right;
   logic        busy;
   logic        game_over;
   logic [2:0]  char_col;
   logic [15:0] score;

   typedef struct {
      logic        dir;
      logic [2:0]  col;
      logic [15:0] score;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   logic prev_pulse = 1'b0;

   jump_controller dut (
      .clk         (clk),
      .rst         (rst),
      .module_en   (module_en),
      .one_ms_tick (one_ms_tick),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .jump_fail   (jump_fail),
      .jump_left   (jump_left),
      .jump_right  (jump_right),
      .busy        (busy),
      .game_over   (game_over),
      .char_col    (char_col),
      .score       (score)
   );

   always #5 clk = ~clk;

   // Pulse monitor: every pulse must match the oldest queued expectation.
   always @(posedge clk) begin
      #2;
      if (jump_left || jump_right) begin
         n_cmp++;
         if ((jump_left && jump_right) !== 1'b0) begin
            n_err++;
            $display("FAIL both_pulses: got left=%0d right=%0d, want at most one", jump_left, jump_right);
         end
         n_cmp++;
         if (prev_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL consecutive_pulse: got pulse two cycles in a row, want single-cycle");
         end
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pulse: got left=%0d right=%0d col=%0d score=%0d, want no pulse",
                     jump_left, jump_right, char_col, score);
         end else begin
            mon_e = exp_q.pop_front();
            if ({jump_right, char_col, score, busy} !== {mon_e.dir, mon_e.col, mon_e.score, 1'b1}) begin
               n_err++;
               $display("FAIL pulse_match: got dir=%0d col=%0d score=%0d busy=%0d, want dir=%0d col=%0d score=%0d busy=1",
                        jump_right, char_col, score, busy, mon_e.dir, mon_e.col, mon_e.score);
            end
         end
      end
      prev_pulse = jump_left | jump_right;
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      one_ms_tick = 1'b1;
      cyc(1);
      one_ms_tick = 1'b0;
      cyc(2);
   endtask

   // Full debounced press and release of the selected buttons.
   task automatic press(input logic l, input logic r);
      btn_left  = l;
      btn_right = r;
      cyc(3);
      for (int i = 0; i < 5; i++) tick();
      btn_left  = 1'b0;
      btn_right = 1'b0;
      cyc(3);
      for (int i = 0; i < 5; i++) tick();
   endtask

   task automatic push_exp(input logic dir, input logic [2:0] col, input logic [15:0] sc);
      exp_t e;
      e.dir   = dir;
      e.col   = col;
      e.score = sc;
      exp_q.push_back(e);
   endtask

   task automatic check_drained(input string name);
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL %s_missing_pulse: got %0d expected pulses outstanding, want 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic check_state(input string name, input logic [2:0] col, input logic [15:0] sc,
                              input logic bz, input logic go);
      n_cmp++;
      if ({char_col, score, busy, game_over} !== {col, sc, bz, go}) begin
         n_err++;
         $display("FAIL %s: got col=%0d score=%0d busy=%0d game_over=%0d, want col=%0d score=%0d busy=%0d game_over=%0d",
                  name, char_col, score, busy, game_over, col, sc, bz, go);
      end
   endtask

   task automatic wait_ready(input string name);
      int k = 0;
      while (busy && k < 60) begin
         tick();
         k++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_busy_timeout: got busy=%0d after %0d ticks, want 0", name, busy, k);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      btn_left    = 1'b0;
      btn_right   = 1'b0;
      jump_fail   = 1'b0;
      one_ms_tick = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({jump_left, jump_right} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_pulses: got left=%0d right=%0d, want 0 0", jump_left, jump_right);
      end
      check_state("reset_state", 3'd3, 16'd0, 1'b0, 1'b0);
   endtask

   task automatic test_debounce_and_busy();
      do_reset();
      btn_left = 1'b1;
      cyc(3);
      for (int i = 0; i < 4; i++) tick();
      btn_left = 1'b0;
      cyc(3);
      for (int i = 0; i < 5; i++) tick();
      check_state("short_press", 3'd3, 16'd0, 1'b0, 1'b0);
      push_exp(1'b0, 3'd2, 16'd1);
      press(1'b1, 1'b0);
      check_drained("debounce");
      check_state("after_left_jump", 3'd2, 16'd1, 1'b1, 1'b0);
      // Jump window ticks 6..15 carry a right press and release; it must be dropped.
      press(1'b0, 1'b1);
      for (int i = 0; i < 24; i++) tick();
      check_state("busy_at_tick39", 3'd2, 16'd1, 1'b1, 1'b0);
      tick();
      check_state("ready_at_tick40", 3'd2, 16'd1, 1'b0, 1'b0);
      push_exp(1'b1, 3'd3, 16'd2);
      press(1'b0, 1'b1);
      check_drained("busy_window");
      wait_ready("busy_window");
   endtask

   task automatic test_edge_bound();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         push_exp(1'b0, 3'(2 - k), 16'(k + 1));
         press(1'b1, 1'b0);
         wait_ready("edge");
      end
      press(1'b1, 1'b0);
      check_state("left_edge", 3'd0, 16'd3, 1'b0, 1'b0);
      check_drained("edge");
   endtask

   task automatic test_simultaneous();
      do_reset();
      press(1'b1, 1'b1);
      check_state("simultaneous", 3'd3, 16'd0, 1'b0, 1'b0);
      check_drained("simultaneous");
   endtask

   task automatic test_fail_priority();
      do_reset();
      push_exp(1'b0, 3'd2, 16'd1);
      press(1'b1, 1'b0);
      wait_ready("fail_pre");
      btn_right = 1'b1;
      cyc(3);
      for (int i = 0; i < 4; i++) tick();
      one_ms_tick = 1'b1;
      cyc(1);
      one_ms_tick = 1'b0;
      jump_fail   = 1'b1;
      cyc(1);
      jump_fail   = 1'b0;
      check_state("fail_priority", 3'd2, 16'd1, 1'b0, 1'b1);
      btn_right = 1'b0;
      cyc(3);
      for (int i = 0; i < 5; i++) tick();
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      check_state("fail_latched", 3'd2, 16'd1, 1'b0, 1'b1);
      check_drained("fail");
      do_reset();
      check_state("fail_reset", 3'd3, 16'd0, 1'b0, 1'b0);
   endtask

   task automatic test_enable_gating();
      do_reset();
      push_exp(1'b0, 3'd2, 16'd1);
      press(1'b1, 1'b0);
      check_state("en_jump", 3'd2, 16'd1, 1'b1, 1'b0);
      module_en = 1'b0;
      cyc(2);
      check_state("en_off_idle", 3'd2, 16'd1, 1'b0, 1'b0);
      press(1'b0, 1'b1);
      check_state("en_off_press", 3'd2, 16'd1, 1'b0, 1'b0);
      module_en = 1'b1;
      cyc(2);
      push_exp(1'b1, 3'd3, 16'd2);
      press(1'b0, 1'b1);
      check_drained("enable");
      check_state("en_resume", 3'd3, 16'd2, 1'b1, 1'b0);
   endtask

   initial begin
      rst         = 1'b1;
      module_en   = 1'b1;
      one_ms_tick = 1'b0;
      btn_left    = 1'b0;
      btn_right   = 1'b0;
      jump_fail   = 1'b0;
      test_reset();
      test_debounce_and_busy();
      test_edge_bound();
      test_simultaneous();
      test_fail_priority();
      test_enable_gating();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
